// File: rtl/fetch_unit_if.sv
// Fetch unit bus: redirect input, instruction-memory request/response and the
// downstream instruction handshake, grouped so benches and checkers bind in one place.
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 16
);
  logic                   redirect_valid_i;
  logic [PC_WIDTH-1:0]    redirect_pc_i;
  logic                   imem_req_o;
  logic [PC_WIDTH-1:0]    imem_addr_o;
  logic                   imem_ready_i;
  logic                   imem_rvalid_i;
  logic [INSTR_WIDTH-1:0] imem_rdata_i;
  logic                   instr_valid_o;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [PC_WIDTH-1:0]    instr_pc_o;
  logic                   instr_ready_i;

  // master: the fetch unit itself; slave: memory plus downstream consumer
  modport master (
    input  redirect_valid_i, redirect_pc_i,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i,
    input  instr_ready_i,
    output imem_req_o, imem_addr_o,
    output instr_valid_o, instr_o, instr_pc_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i,
    output instr_ready_i,
    input  imem_req_o, imem_addr_o,
    input  instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: REQ issues pc, WAIT collects data,
// HOLD presents it downstream; redirects squash any in-flight response.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 10,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus,
  output logic [1:0]   state_dbg_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   squash_q, squash_d;
  logic                   started_q, started_d;
  logic                   instr_valid_q, instr_valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
  logic                   imem_req;

  // Handshakes: a request transfers on a cycle with imem_req_o && imem_ready_i;
  // an instruction transfers on a cycle with instr_valid_o && instr_ready_i.
  // started_q keeps the request low until the first edge after reset release.
  assign imem_req = (state_q == ST_REQ) && started_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      squash_q      <= 1'b0;
      started_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      started_q     <= started_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    started_d     = 1'b1;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    if (bus.redirect_valid_i) begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (bus.redirect_valid_i) begin
          pc_d = bus.redirect_pc_i;
          // A request accepted alongside the redirect still returns data; drop it.
          if (imem_req && bus.imem_ready_i) begin
            squash_d = 1'b1;
            state_d  = ST_WAIT;
          end
        end else if (imem_req && bus.imem_ready_i) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.redirect_valid_i) begin
          pc_d = bus.redirect_pc_i;
          if (bus.imem_rvalid_i) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (bus.imem_rvalid_i) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            instr_valid_d = 1'b1;
            instr_d       = bus.imem_rdata_i;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + PC_WIDTH'(1);
            state_d       = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (bus.redirect_valid_i) begin
          pc_d    = bus.redirect_pc_i;
          state_d = ST_REQ;
        end else if (bus.instr_ready_i) begin
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  assign bus.imem_req_o    = imem_req;
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_valid_o = instr_valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_pc_o    = instr_pc_q;
  assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random memory/consumer/redirect traffic scored against an
// architectural next-pc model, plus directed redirect, hold, wrap and reset cases.
module tb_fetch_unit;
  localparam int             PW      = 10;
  localparam int             IW      = 16;
  localparam logic [PW-1:0]  RST_PC  = 10'h000;
  localparam logic [PW-1:0]  RST_PC2 = 10'h3FF;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic [1:0] dbg_state, dbg_state2;

  fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) u_if ();
  fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) u_if2 ();

  fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(u_if), .state_dbg_o(dbg_state));

  fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(RST_PC2)) dut2 (
    .clk(clk), .reset_n(rst2_n), .bus(u_if2), .state_dbg_o(dbg_state2));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoring ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return IW'(32'hA000 + 32'(a));
  endfunction

  // ---------------- reference model ----------------
  // Architectural view: the next delivered instruction is the one after the last
  // consumed one, or the redirect target if a redirect happened since.
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] model_pc;
  logic [PW-1:0] held_pc, held_addr;
  logic [IW-1:0] held_instr;
  bit            hold_exp = 1'b0;
  bit            req_hold_exp = 1'b0;
  int            epoch = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_q.push_back(RST_PC);
      model_pc     = RST_PC;
      hold_exp     = 1'b0;
      req_hold_exp = 1'b0;
      epoch++;
    end else begin
      hold_exp     = u_if.instr_valid_o && !u_if.instr_ready_i && !u_if.redirect_valid_i;
      held_pc      = u_if.instr_pc_o;
      held_instr   = u_if.instr_o;
      req_hold_exp = u_if.imem_req_o && !u_if.imem_ready_i && !u_if.redirect_valid_i;
      held_addr    = u_if.imem_addr_o;
      if (u_if.redirect_valid_i) begin
        exp_q.delete();
        model_pc = u_if.redirect_pc_i;
        exp_q.push_back(model_pc);
        epoch++;
      end else if (u_if.instr_valid_o && u_if.instr_ready_i) begin
        model_pc = model_pc + 1'b1;
        exp_q.push_back(model_pc);
        epoch++;
      end
    end
  end

  // ---------------- monitor ----------------
  int            seen_epoch = -1;
  int            delivered = 0;
  logic [PW-1:0] exp_pc;

  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_exp) begin
        check("hold_valid", u_if.instr_valid_o, 1'b1);
        check("hold_pc", u_if.instr_pc_o, held_pc);
        check("hold_instr", u_if.instr_o, held_instr);
      end
      if (req_hold_exp) begin
        check("req_stable", u_if.imem_req_o, 1'b1);
        check("addr_stable", u_if.imem_addr_o, held_addr);
      end
      if (u_if.instr_valid_o) check("no_req_while_valid", u_if.imem_req_o, 1'b0);
      if (u_if.instr_valid_o && seen_epoch != epoch) begin
        seen_epoch = epoch;
        delivered++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_instr: got pc 0x%0h with no instruction expected", u_if.instr_pc_o);
        end else begin
          exp_pc = exp_q.pop_front();
          if (u_if.instr_pc_o !== exp_pc || u_if.instr_o !== mem_word(exp_pc)) begin
            errors++;
            $display("FAIL instr: got pc 0x%0h data 0x%0h expected pc 0x%0h data 0x%0h",
                     u_if.instr_pc_o, u_if.instr_o, exp_pc, mem_word(exp_pc));
          end
        end
      end
    end
  end

  // ---------------- driver / memory model ----------------
  bit            pending = 1'b0;
  logic [PW-1:0] pend_addr = '0;
  int            pend_cnt = 0;
  int            lat_min = 0, lat_max = 0, p_ready = 100, p_iready = 100, p_redir = 0;
  bit            arm_after3 = 1'b0, fire_redirect = 1'b0, watch_addr = 1'b0, arm_on_rvalid = 1'b0;
  int            watch_033 = 0;

  task automatic cycle();
    @(posedge clk);
    if (!reset_n) begin
      pending = 1'b0;
    end else begin
      if (watch_addr && u_if.imem_req_o) begin
        check("req_after_redirect", u_if.imem_addr_o, 10'h100);
        watch_addr = 1'b0;
      end
      if (watch_033 == 1) begin
        check("coincident_valid", u_if.instr_valid_o, 1'b0);
        check("coincident_req", u_if.imem_req_o, 1'b1);
        check("coincident_addr", u_if.imem_addr_o, 10'h2A0);
      end
      if (watch_033 > 0) watch_033--;
      if (u_if.imem_rvalid_i) pending = 1'b0;
      if (u_if.imem_req_o && u_if.imem_ready_i) begin
        pending   = 1'b1;
        pend_addr = u_if.imem_addr_o;
        pend_cnt  = $urandom_range(lat_max, lat_min);
        if (arm_after3 && u_if.imem_addr_o == 10'd3) begin
          fire_redirect = 1'b1;
          arm_after3    = 1'b0;
        end
      end
    end
    #1;
    u_if.imem_rvalid_i = pending && pend_cnt == 0;
    u_if.imem_rdata_i  = u_if.imem_rvalid_i ? mem_word(pend_addr) : IW'($urandom);
    if (pending && pend_cnt > 0) pend_cnt--;
    u_if.imem_ready_i     = $urandom_range(99, 0) < p_ready;
    u_if.instr_ready_i    = $urandom_range(99, 0) < p_iready;
    u_if.redirect_valid_i = 1'b0;
    u_if.redirect_pc_i    = PW'($urandom);
    if (fire_redirect) begin
      u_if.redirect_valid_i = 1'b1;
      u_if.redirect_pc_i    = 10'h100;
      fire_redirect         = 1'b0;
      watch_addr            = 1'b1;
    end else if (arm_on_rvalid && u_if.imem_rvalid_i) begin
      u_if.redirect_valid_i = 1'b1;
      u_if.redirect_pc_i    = 10'h2A0;
      arm_on_rvalid         = 1'b0;
      watch_033             = 2;
    end else if ($urandom_range(99, 0) < p_redir) begin
      u_if.redirect_valid_i = 1'b1;
      if ($urandom_range(3, 0) == 0) u_if.redirect_pc_i = 10'h3FC + PW'($urandom_range(3, 0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, u_if.instr_valid_o, 1'b0);
    check({tag, "_instr"}, u_if.instr_o, '0);
    check({tag, "_pc"}, u_if.instr_pc_o, '0);
    check({tag, "_req"}, u_if.imem_req_o, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  logic [1:0] state_at_reset;
  int         d0;

  initial begin
    u_if.redirect_valid_i = 1'b0;
    u_if.redirect_pc_i    = '0;
    u_if.imem_ready_i     = 1'b1;
    u_if.imem_rvalid_i    = 1'b0;
    u_if.imem_rdata_i     = '0;
    u_if.instr_ready_i    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    state_at_reset = dbg_state;
    #1 reset_n = 1'b1;
    check("req_before_first_edge", u_if.imem_req_o, 1'b0);
    cycle();
    check("first_req", u_if.imem_req_o, 1'b1);
    check("first_addr", u_if.imem_addr_o, RST_PC);

    // zero-wait memory, always-ready consumer: pcs 0,1,2
    for (int i = 0; i < 60 && delivered < 3; i++) cycle();
    check("first_three_delivered", delivered >= 3, 1'b1);

    // redirect one cycle after request to addr 3 is accepted
    lat_min = 2; lat_max = 2; arm_after3 = 1'b1;
    for (int i = 0; i < 60 && delivered < 4; i++) cycle();
    check("redirect_after3_done", {arm_after3, watch_addr}, 2'b00);

    // consumer stalls while an instruction is held
    lat_min = 0; lat_max = 0; p_iready = 0;
    for (int i = 0; i < 30 && !u_if.instr_valid_o; i++) cycle();
    repeat (6) cycle();
    p_iready = 100;

    // redirect coincident with read data
    lat_min = 1; lat_max = 1;
    repeat (5) cycle();
    arm_on_rvalid = 1'b1;
    for (int i = 0; i < 30 && (arm_on_rvalid || watch_033 > 0); i++) cycle();
    check("coincident_done", {arm_on_rvalid, watch_033 == 0}, 2'b01);

    // random traffic
    lat_min = 0; lat_max = 3; p_ready = 60; p_iready = 60; p_redir = 8;
    repeat (1500) cycle();
    check("random_progress", delivered > 100, 1'b1);

    // asynchronous reset in the middle of WAIT
    p_redir = 0; p_ready = 100; p_iready = 100; lat_min = 2; lat_max = 2;
    repeat (4) cycle();
    for (int i = 0; i < 30 && !pending; i++) cycle();
    check("wait_reached", pending, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    check("async_reset_state", dbg_state, state_at_reset);
    pending = 1'b0;
    #13 reset_n = 1'b1;
    check("req_after_release", u_if.imem_req_o, 1'b0);
    cycle();
    check("restart_req", u_if.imem_req_o, 1'b1);
    check("restart_addr", u_if.imem_addr_o, RST_PC);
    d0 = delivered;
    lat_min = 0; lat_max = 0;
    repeat (40) cycle();
    check("progress_after_reset", (delivered - d0) >= 5, 1'b1);

    check("wrap_instance_seen", n2, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- second instance: RESET_PC at all-ones ----------------
  logic          p2;
  logic [PW-1:0] a2;
  int            n2 = 0;
  logic [PW-1:0] e2;

  initial begin
    u_if2.redirect_valid_i = 1'b0;
    u_if2.redirect_pc_i    = '0;
    u_if2.imem_ready_i     = 1'b1;
    u_if2.imem_rvalid_i    = 1'b0;
    u_if2.imem_rdata_i     = '0;
    u_if2.instr_ready_i    = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst2_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      p2 = u_if2.imem_req_o && u_if2.imem_ready_i;
      a2 = u_if2.imem_addr_o;
      #1;
      u_if2.imem_rvalid_i = p2;
      u_if2.imem_rdata_i  = mem_word(a2);
    end
  end

  always @(negedge clk) begin
    if (!rst2_n && $time > 10 && $time < 20) check("wrap_reset_state", dbg_state2, 2'd0 ^ state_at_reset ^ state_at_reset);
    if (rst2_n && u_if2.instr_valid_o && n2 < 3) begin
      e2 = RST_PC2 + PW'(n2);
      check("wrap_pc", u_if2.instr_pc_o, e2);
      check("wrap_instr", u_if2.instr_o, mem_word(e2));
      n2++;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 10: width of the program counter and instruction address.
REQ-002 Parameter INSTR_WIDTH, default 16: width of the instruction word.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1: asynchronous, active-low reset.
REQ-006 Port redirect_valid_i  input  1: branch/jump redirect request; acts as the next-PC mux select.
REQ-007 Port redirect_pc_i  input  PC_WIDTH: redirect target PC.
REQ-008 Port imem_req_o  output  1: instruction memory request valid.
REQ-009 Port imem_addr_o  output  PC_WIDTH: request address, equal to the current PC.
REQ-010 Port imem_ready_i  input  1: memory accepts the request this cycle.
REQ-011 Port imem_rvalid_i  input  1: read data valid.
REQ-012 Port imem_rdata_i  input  INSTR_WIDTH: read data.
REQ-013 Port instr_valid_o  output  1: fetched instruction available downstream.
REQ-014 Port instr_o  output  INSTR_WIDTH: fetched instruction.
REQ-015 Port instr_pc_o  output  PC_WIDTH: PC of instr_o.
REQ-016 Port instr_ready_i  input  1: downstream consumes instr_o this cycle.

Function
REQ-017 The block SHALL implement FSM states REQ, WAIT and HOLD, with at most one memory request outstanding.
- REQ: imem_req_o=1, imem_addr_o=pc.
- REQ -> WAIT when imem_ready_i=1.
REQ-018 In WAIT, when imem_rvalid_i=1 and the request is not squashed, the block SHALL:
- load instr_o<=imem_rdata_i, instr_pc_o<=request address, instr_valid_o<=1;
- set pc<=pc+1, modulo 2^PC_WIDTH (wraps all-ones -> 0);
- go to HOLD.
REQ-019 In HOLD, the block SHALL hold instr_valid_o/instr_o/instr_pc_o stable until instr_ready_i=1.
- On that cycle: clear instr_valid_o, go to REQ.
- Minimum issue interval: one instruction per 3 cycles, given zero-wait memory.
REQ-020 instr_valid_o SHALL never drop without instr_ready_i=1 or a redirect.
REQ-021 On redirect_valid_i=1 in any state, the block SHALL:
- set pc<=redirect_pc_i, with priority over pc+1;
- clear instr_valid_o the same edge;
- go to REQ, except from WAIT (see REQ-022).
REQ-022 On a redirect while in WAIT, or in REQ with imem_ready_i=1 the same cycle, the block SHALL:
- set the squash flag and enter or stay in WAIT;
- on the next imem_rvalid_i: discard the data, clear squash, go to REQ without loading instr_* or changing pc.
REQ-023 A redirect coincident with imem_rvalid_i in WAIT SHALL discard that data; redirect wins.
REQ-024 A redirect coincident with instr_ready_i in HOLD SHALL count the held instruction as consumed, with pc<=redirect_pc_i.
REQ-025 imem_addr_o SHALL be stable while imem_req_o=1 and imem_ready_i=0, unless a redirect occurs.

Reset
REQ-026 While reset_n=0, independent of clk, the block SHALL hold:
- pc=RESET_PC, state=REQ, squash=0;
- instr_valid_o=0, instr_o=0, instr_pc_o=0;
- imem_req_o=0.
REQ-027 imem_req_o SHALL first assert on the first rising clk edge after reset_n deasserts.
REQ-028 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_rvalid_i after reset SHALL be ignored unless the block is in WAIT.

Verification
REQ-029 Reset, then zero-wait memory, instr_ready_i=1, rdata=0xA000+addr -> instr_o sequence 0xA000, 0xA001, 0xA002 with instr_pc_o 0, 1, 2.
REQ-030 instr_ready_i=0 for 5 cycles while instr_valid_o=1 -> instr_o/instr_pc_o unchanged, imem_req_o=0 throughout.
REQ-031 Redirect to 0x100 one cycle after an accepted request to addr 3 -> rvalid data for addr 3 dropped; next request addr 0x100; next instr_pc_o 0x100.
REQ-032 RESET_PC=0x3FF, PC_WIDTH=10 -> fetch pcs 0x3FF then 0x000.
REQ-033 Redirect coincident with imem_rvalid_i -> instr_valid_o stays 0; next imem_addr_o = redirect_pc_i.
REQ-034 reset_n pulsed low mid-WAIT, asynchronous to clk -> outputs zero immediately; first request after release at RESET_PC.
